// File: rtl/data_mem_responder.sv
// Single-port data memory responder: captures one load/store request, waits a fixed
// latency, then acknowledges with little-endian sub-word data or an alignment fault.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wen,
    input  logic [1:0]  rwtype,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        sign_extend,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_ack;
    logic          r_err;
    logic          r_busy;
    logic [31:0]   r_rdata;

    logic          r_wen;
    logic [1:0]    r_type;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_sext;

    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [31:0]   w_word;
    logic          w_fault;
    logic          w_mem_we;
    logic          w_unused_addr;

    function automatic logic f_fault(input logic [1:0] t, input logic [1:0] off);
        case (t)
            2'b00:   f_fault = (off != 2'b00);
            2'b01:   f_fault = off[0];
            2'b10:   f_fault = 1'b0;
            default: f_fault = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] t,
                                           input logic [1:0] off, input logic sext);
        logic [15:0] h;
        logic [7:0]  b;
        h = off[1] ? word[31:16] : word[15:0];
        b = word[{off, 3'b000} +: 8];
        case (t)
            2'b00:   f_load = word;
            2'b01:   f_load = {{16{sext & h[15]}}, h};
            2'b10:   f_load = {{24{sext & b[7]}}, b};
            default: f_load = '0;
        endcase
    endfunction

    // Read-modify-write merge so only the addressed lanes change.
    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] t, input logic [1:0] off);
        logic [31:0] m;
        m = old;
        case (t)
            2'b00:   m = d;
            2'b01:   m[{off[1], 4'b0000} +: 16] = d[15:0];
            2'b10:   m[{off, 3'b000} +: 8] = d[7:0];
            default: m = old;
        endcase
        return m;
    endfunction

    assign w_idx         = r_addr[AW+1:2];
    assign w_off         = r_addr[1:0];
    assign w_word        = r_mem[w_idx];
    assign w_fault       = f_fault(r_type, w_off);
    assign w_mem_we      = (r_state == S_RESP) && !rst && r_wen && !w_fault;
    assign w_unused_addr = ^addr[31:AW+2];

    // Request capture: data registers only, no reset needed.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && req) begin
            r_wen   <= wen;
            r_type  <= rwtype;
            r_addr  <= addr[AW+1:0];
            r_wdata <= wdata;
            r_sext  <= sign_extend;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_cnt   <= 4'(LATENCY - 1);
                        r_busy  <= 1'b1;
                        r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_RESP;
                end
                S_RESP: begin
                    r_ack   <= 1'b1;
                    r_err   <= w_fault;
                    r_rdata <= (w_fault || r_wen) ? 32'h0 : f_load(w_word, r_type, w_off, r_sext);
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_idx] <= f_merge(w_word, r_wdata, r_type, w_off);
    end

    assign ack   = r_ack;
    assign err   = r_err;
    assign rdata = r_rdata;
    assign busy  = r_busy;

endmodule
